// File: rtl/mmio_controller_pkg.sv
// -----------------------------------------------------------------------------
// mmio_controller_pkg
// Shared definitions for memory-mapped peripherals on the CPU data bus:
//   - I/O register addresses (HEX, LEDR, KEY, SW)
//   - debounce FSM state type
//   - seven-segment glyph table (hex digit -> active-low {g,f,e,d,c,b,a})
// -----------------------------------------------------------------------------
package mmio_controller_pkg;

  localparam logic [31:0] IO_ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] IO_ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] IO_ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] IO_ADDR_SW   = 32'hF000_0014;

  // Seven-segment pattern shown after reset ("0").
  localparam logic [6:0] SEG_ZERO = 7'b100_0000;

  typedef enum logic {
    DEB_STABLE   = 1'b0,
    DEB_COUNTING = 1'b1
  } deb_state_e;

  // Hex digit to active-low segment pattern, order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b100_0000;
      4'h1:    seg = 7'b111_1001;
      4'h2:    seg = 7'b010_0100;
      4'h3:    seg = 7'b011_0000;
      4'h4:    seg = 7'b001_1001;
      4'h5:    seg = 7'b001_0010;
      4'h6:    seg = 7'b000_0010;
      4'h7:    seg = 7'b111_1000;
      4'h8:    seg = 7'b000_0000;
      4'h9:    seg = 7'b001_0000;
      4'hA:    seg = 7'b000_1000;
      4'hB:    seg = 7'b000_0011;
      4'hC:    seg = 7'b100_0110;
      4'hD:    seg = 7'b010_0001;
      4'hE:    seg = 7'b000_0110;
      4'hF:    seg = 7'b000_1110;
      default: seg = 7'b111_1111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/mmio_controller_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
// Two-flop synchronizer followed by a group-wide debounce FSM. The debounced
// vector only changes after the synchronized vector has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; the whole vector is loaded at once.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   din        : raw asynchronous input vector (already active-high)
//   dout       : debounced vector (registered)
// -----------------------------------------------------------------------------
module debouncer
  import mmio_controller_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc_s;
  deb_state_e       state_q, state_d;

  assign cnt_inc_s = cnt_q + CW'(1);

  // Next-state logic for the debounce FSM, counter and accepted value.
  // The STABLE->COUNTING transition is itself the first stable cycle, so
  // acceptance happens when the incremented count reaches CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    case (state_q)
      DEB_STABLE: begin
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          state_d = DEB_COUNTING;
        end else begin
          state_d = DEB_STABLE;
        end
      end
      DEB_COUNTING: begin
        if (sync2_q != deb_q) begin
          if (cnt_inc_s == CNT_LAST) begin
            deb_d   = sync2_q;
            cnt_d   = '0;
            state_d = DEB_STABLE;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          // Input returned to the accepted value: treat as a glitch.
          cnt_d   = '0;
          state_d = DEB_STABLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = DEB_STABLE;
      end
    endcase
  end

  // Synchronizer flops and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      state_q <= DEB_STABLE;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/mmio_controller.sv
// -----------------------------------------------------------------------------
// mmio_controller
// Memory-mapped I/O block beside data memory on the single-cycle CPU's
// load/store path. Decodes exact addresses, holds HEX and LEDR registers and
// returns debounced KEY/SW values on loads.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   addr/wrEn/wdata : CPU data bus (store when wrEn at rising edge)
//   rdata, hit      : combinational load data and address-match flag
//   KEY, SW         : raw asynchronous pushbuttons (active-low) / switches
//   LEDR, HEX0..3   : registered LED and seven-segment (active-low) drives
// -----------------------------------------------------------------------------
module mmio_controller
  import mmio_controller_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = IO_ADDR_HEX,
  parameter logic [DBITS-1:0] ADDR_LEDR       = IO_ADDR_LEDR,
  parameter logic [DBITS-1:0] ADDR_KEY        = IO_ADDR_KEY,
  parameter logic [DBITS-1:0] ADDR_SW         = IO_ADDR_SW,
  parameter int               DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q;
  logic [3:0]  key_deb_s;
  logic [9:0]  sw_deb_s;
  logic        sel_hex_s, sel_ledr_s, sel_key_s, sel_sw_s;
  logic        unused_wdata_s;

  assign unused_wdata_s = ^wdata[DBITS-1:16];

  assign sel_hex_s  = (addr == ADDR_HEX);
  assign sel_ledr_s = (addr == ADDR_LEDR);
  assign sel_key_s  = (addr == ADDR_KEY);
  assign sel_sw_s   = (addr == ADDR_SW);

  debouncer #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_deb (
    .clk  (clk),
    .reset(reset),
    .din  (~KEY),
    .dout (key_deb_s)
  );

  debouncer #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_deb (
    .clk  (clk),
    .reset(reset),
    .din  (SW),
    .dout (sw_deb_s)
  );

  // Store decode: only HEX and LEDR are writable; everything else is ignored.
  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    if (wrEn && sel_hex_s) begin
      hex_d = wdata[15:0];
    end else if (wrEn && sel_ledr_s) begin
      ledr_d = wdata[9:0];
    end else begin
      hex_d  = hex_q;
      ledr_d = ledr_q;
    end
  end

  // Output registers. Segment drives are registered from hex_d so they
  // update on the same edge as hex_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q  <= 16'h0000;
      ledr_q <= 10'h000;
      hex0_q <= SEG_ZERO;
      hex1_q <= SEG_ZERO;
      hex2_q <= SEG_ZERO;
      hex3_q <= SEG_ZERO;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      hex0_q <= seg7_decode(hex_d[3:0]);
      hex1_q <= seg7_decode(hex_d[7:4]);
      hex2_q <= seg7_decode(hex_d[11:8]);
      hex3_q <= seg7_decode(hex_d[15:12]);
    end
  end

  // Zero-latency load mux; follows addr even while reset is asserted.
  always_comb begin
    rdata = '0;
    hit   = 1'b0;
    if (sel_hex_s) begin
      rdata = {{(DBITS-16){1'b0}}, hex_q};
      hit   = 1'b1;
    end else if (sel_ledr_s) begin
      rdata = {{(DBITS-10){1'b0}}, ledr_q};
      hit   = 1'b1;
    end else if (sel_key_s) begin
      rdata = {{(DBITS-4){1'b0}}, key_deb_s};
      hit   = 1'b1;
    end else if (sel_sw_s) begin
      rdata = {{(DBITS-10){1'b0}}, sw_deb_s};
      hit   = 1'b1;
    end else begin
      rdata = '0;
      hit   = 1'b0;
    end
  end

  assign LEDR = ledr_q;
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;

endmodule

// File: tb/tb_mmio_controller.sv
module tb_mmio_controller;

  localparam int D = 8;
  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrEn;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [3:0]  m_k1, m_k2, m_kdeb;
  logic [9:0]  m_s1, m_s2, m_sdeb;
  int          m_krun, m_srun;
  logic [6:0]  glyph [16];

  always #5 clk = ~clk;

  mmio_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wrEn(wrEn), .wdata(wdata),
    .rdata(rdata), .hit(hit), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  function automatic logic exp_hit(input logic [31:0] a);
    return (a == A_HEX) || (a == A_LEDR) || (a == A_KEY) || (a == A_SW);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == A_HEX)       return 32'(m_hex);
    else if (a == A_LEDR) return 32'(m_ledr);
    else if (a == A_KEY)  return 32'(m_kdeb);
    else if (a == A_SW)   return 32'(m_sdeb);
    else                  return 32'd0;
  endfunction

  // Model of one rising edge: debounced value follows the synchronized value
  // once it has differed for D consecutive edges.
  task automatic model_edge();
    if (reset) begin
      m_hex = 16'd0; m_ledr = 10'd0;
      m_k1 = 4'd0; m_k2 = 4'd0; m_kdeb = 4'd0; m_krun = 0;
      m_s1 = 10'd0; m_s2 = 10'd0; m_sdeb = 10'd0; m_srun = 0;
    end else begin
      if (wrEn && addr == A_HEX)  m_hex  = wdata[15:0];
      if (wrEn && addr == A_LEDR) m_ledr = wdata[9:0];
      if (m_k2 != m_kdeb) begin
        m_krun++;
        if (m_krun == D) begin m_kdeb = m_k2; m_krun = 0; end
      end else m_krun = 0;
      if (m_s2 != m_sdeb) begin
        m_srun++;
        if (m_srun == D) begin m_sdeb = m_s2; m_srun = 0; end
      end else m_srun = 0;
      m_k2 = m_k1; m_k1 = ~KEY;
      m_s2 = m_s1; m_s1 = SW;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wrEn = 1'b1; addr = A_LEDR; wdata = 32'hFFFF_FFFF;
    KEY = 4'hF; SW = 10'h000;
    repeat (3) tick();
    checks++;
    if (LEDR !== 10'h000) begin errors++; $display("FAIL reset_ledr got=%h exp=000", LEDR); end
    checks++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {4{7'b1000000}}) begin
      errors++; $display("FAIL reset_hex got=%h_%h_%h_%h exp=40 each", HEX3, HEX2, HEX1, HEX0);
    end
    wrEn = 1'b0; addr = A_SW; #1;
    checks++;
    if (hit !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL reset_decode hit=%b rdata=%h exp hit=1 rdata=0", hit, rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_hex_store();
    addr = A_HEX; wdata = 32'hA5A5_BEEF; wrEn = 1'b1;
    tick();
    wrEn = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0000_BEEF || hit !== 1'b1) begin
      errors++; $display("FAIL hex_load rdata=%h hit=%b exp=0000beef hit=1", rdata, hit);
    end
    checks++;
    if (HEX3 !== glyph[11] || HEX2 !== glyph[14] || HEX1 !== glyph[14] || HEX0 !== glyph[15]) begin
      errors++; $display("FAIL hex_glyphs got=%h_%h_%h_%h exp=03_06_06_0e", HEX3, HEX2, HEX1, HEX0);
    end
  endtask

  task automatic test_ledr_store();
    addr = A_LEDR; wdata = 32'hFFFF_FFFF; wrEn = 1'b1;
    tick();
    wrEn = 1'b0; #1;
    checks++;
    if (LEDR !== 10'h3FF || rdata !== 32'h0000_03FF) begin
      errors++; $display("FAIL ledr_store LEDR=%h rdata=%h exp=3ff/000003ff", LEDR, rdata);
    end
    addr = A_KEY; wdata = 32'hFFFF_FFFF; wrEn = 1'b1;
    tick();
    wrEn = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL key_readonly rdata=%h exp=0", rdata); end
    checks++;
    if (LEDR !== 10'h3FF || HEX0 !== glyph[15]) begin
      errors++; $display("FAIL key_store_side LEDR=%h HEX0=%h exp=3ff/0e", LEDR, HEX0);
    end
  endtask

  task automatic test_key_debounce();
    logic [31:0] e;
    KEY = 4'b1110; addr = A_KEY;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = (c >= 10) ? 32'd1 : 32'd0;
      checks++;
      if (rdata !== e || rdata !== exp_rdata(addr)) begin
        errors++; $display("FAIL key_timing c=%0d rdata=%h exp=%h", c, rdata, e);
      end
    end
    KEY = 4'hF;
    repeat (12) tick();
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL key_release rdata=%h exp=0", rdata); end
  endtask

  task automatic test_sw_glitch();
    SW = 10'h001; addr = A_SW;
    repeat (5) tick();
    SW = 10'h000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL sw_glitch c=%0d rdata=%h exp=0", c, rdata); end
    end
  endtask

  task automatic test_sw_hold();
    logic [31:0] e;
    SW = 10'h2A5; addr = A_SW;
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = (c >= 10) ? 32'h0000_02A5 : 32'd0;
      checks++;
      if (rdata !== e) begin errors++; $display("FAIL sw_hold c=%0d rdata=%h exp=%h", c, rdata, e); end
    end
  endtask

  task automatic test_reset_priority();
    logic [31:0] e;
    reset = 1'b1; wrEn = 1'b1; addr = A_LEDR; wdata = 32'h0000_0155;
    tick();
    reset = 1'b0; wrEn = 1'b0; #1;
    checks++;
    if (LEDR !== 10'h000) begin errors++; $display("FAIL reset_priority LEDR=%h exp=000", LEDR); end
    // SW still 2A5: enter COUNTING, then reset part way through
    addr = A_SW;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL mid_count_reset rdata=%h exp=0", rdata); end
    for (int c = 1; c <= 12; c++) begin
      tick();
      e = (c >= 10) ? 32'h0000_02A5 : 32'd0;
      checks++;
      if (rdata !== e) begin errors++; $display("FAIL post_reset_sw c=%0d rdata=%h exp=%h", c, rdata, e); end
    end
  endtask

  task automatic test_unmapped();
    addr = A_HEX; wdata = 32'h0000_1234; wrEn = 1'b1;
    tick();
    addr = 32'hF000_0008; wdata = 32'hFFFF_FFFF; wrEn = 1'b1; #1;
    checks++;
    if (hit !== 1'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL unmapped_decode hit=%b rdata=%h exp 0/0", hit, rdata);
    end
    tick();
    wrEn = 1'b0; addr = A_HEX; #1;
    checks++;
    if (rdata !== 32'h0000_1234 || LEDR !== 10'h000 || HEX3 !== glyph[1]) begin
      errors++; $display("FAIL unmapped_store rdata=%h LEDR=%h HEX3=%h exp=1234/000/79", rdata, LEDR, HEX3);
    end
    addr = 32'hF000_0001; #1;
    checks++;
    if (hit !== 1'b0 || rdata !== 32'd0) begin
      errors++; $display("FAIL near_alias hit=%b rdata=%h exp 0/0", hit, rdata);
    end
  endtask

  task automatic test_random();
    int hold_k, hold_s;
    hold_k = 0; hold_s = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: addr = A_HEX;
        1: addr = A_LEDR;
        2: addr = A_KEY;
        3: addr = A_SW;
        4: addr = 32'hF000_0008;
        default: addr = $urandom;
      endcase
      wrEn  = ($urandom_range(0, 1) == 1);
      wdata = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      if (hold_k == 0) begin KEY = 4'($urandom); hold_k = $urandom_range(1, 14); end
      else hold_k--;
      if (hold_s == 0) begin SW = 10'($urandom); hold_s = $urandom_range(1, 14); end
      else hold_s--;
      #1;
      checks++;
      if (hit !== exp_hit(addr) || rdata !== exp_rdata(addr)) begin
        errors++; $display("FAIL rand_load i=%0d addr=%h hit=%b rdata=%h exp hit=%b rdata=%h",
                           i, addr, hit, rdata, exp_hit(addr), exp_rdata(addr));
      end
      tick();
      checks++;
      if (LEDR !== m_ledr || HEX0 !== glyph[m_hex[3:0]] || HEX1 !== glyph[m_hex[7:4]] ||
          HEX2 !== glyph[m_hex[11:8]] || HEX3 !== glyph[m_hex[15:12]]) begin
        errors++; $display("FAIL rand_outputs i=%0d LEDR=%h exp=%h HEX=%h_%h_%h_%h model_hex=%h",
                           i, LEDR, m_ledr, HEX3, HEX2, HEX1, HEX0, m_hex);
      end
    end
    reset = 1'b0; wrEn = 1'b0;
  endtask

  initial begin
    glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
    glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
    glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    reset = 1'b1; addr = 32'd0; wrEn = 1'b0; wdata = 32'd0; KEY = 4'hF; SW = 10'h000;
    test_reset();
    test_hex_store();
    test_ledr_store();
    test_key_debounce();
    test_sw_glitch();
    test_sw_hold();
    test_reset_priority();
    test_unmapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
